// File: rtl/ss_pkg.sv
// Shared types and buffer-layout helpers for the save-state sequencer.
package ss_pkg;

  localparam logic [7:0] SS_IDX_SLOT = 8'd127;

  typedef enum logic [3:0] {
    IDLE,
    SV_ADDR,
    SV_MEM,
    LD_IDX,
    LD_CHK,
    LD_MEM,
    LD_STB,
    DONE,
    ERR
  } ss_state_t;

  typedef enum logic [1:0] {
    STB_IDLE,
    STB_HIGH,
    STB_HOLD
  } stb_state_t;

  // Buffer layout: register slots at 0..reg_cnt-1, map index next, checksum after it.
  function automatic logic [7:0] buf_idx_addr(input int reg_cnt);
    return 8'(reg_cnt);
  endfunction

  function automatic logic [7:0] buf_chk_addr(input int reg_cnt);
    return 8'(reg_cnt + 1);
  endfunction

endpackage

// File: rtl/ss_strobe_gen.sv
// Mapper strobe timer: STB_LEN high clocks, then one low hold clock flagged by done_o.
module ss_strobe_gen #(
  parameter int STB_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic stb_o,
  output logic done_o
);
  import ss_pkg::*;

  localparam logic [7:0] HIGH_LAST = 8'(STB_LEN - 1);

  stb_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stb_o   = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      STB_IDLE: begin
        if (start_i) begin
          state_d = STB_HIGH;
          cnt_d   = '0;
        end
      end
      STB_HIGH: begin
        stb_o = 1'b1;
        if (cnt_q == HIGH_LAST) state_d = STB_HOLD;
        else                    cnt_d   = cnt_q + 8'd1;
      end
      STB_HOLD: begin
        done_o  = 1'b1;
        state_d = STB_IDLE;
      end
      default: state_d = STB_IDLE;
    endcase
  end

endmodule

// File: rtl/ss_seq.sv
// Save-state sequencer: snapshots mapper registers into a buffer and reloads them.
// Optional checksum slot enabled by defining SS_SEQ_CHECKSUM_EN.
module ss_seq #(
  parameter int REG_CNT = 16,
  parameter int STB_LEN = 4,
  parameter int SETTLE  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_save,
  input  logic       cmd_load,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  output logic       ss_stb,
  input  logic [7:0] ss_rdat,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdat,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdat
);
  import ss_pkg::*;

  localparam logic [7:0] LAST_SLOT   = 8'(REG_CNT - 1);
  localparam logic [7:0] IDX_ADDR    = buf_idx_addr(REG_CNT);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
`ifdef SS_SEQ_CHECKSUM_EN
  localparam logic [7:0] CHK_ADDR    = buf_chk_addr(REG_CNT);
`endif

  ss_state_t  state_q, state_d;
  logic [7:0] slot_q, slot_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] idx_q, idx_d;
  logic       have_q, have_d;
  logic       err_q, err_d;
  logic [7:0] ss_addr_q, ss_addr_d;
  logic [7:0] ss_wdat_q, ss_wdat_d;
  logic       ss_we_q, ss_we_d;
  logic       mem_req_q, mem_req_d;
  logic       mem_we_q, mem_we_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdat_q, mem_wdat_d;
  logic       stb_start_q, stb_start_d;
  logic       stb_done;
`ifdef SS_SEQ_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] chk_q, chk_d;
  logic       chk_ph_q, chk_ph_d;
`endif

  ss_strobe_gen #(.STB_LEN(STB_LEN)) u_strobe (
    .clk     (clk),
    .rst     (rst),
    .start_i (stb_start_q),
    .stb_o   (ss_stb),
    .done_o  (stb_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      have_q      <= 1'b0;
      err_q       <= 1'b0;
      ss_addr_q   <= '0;
      ss_wdat_q   <= '0;
      ss_we_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdat_q  <= '0;
      stb_start_q <= 1'b0;
`ifdef SS_SEQ_CHECKSUM_EN
      sum_q       <= '0;
      chk_q       <= '0;
      chk_ph_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      have_q      <= have_d;
      err_q       <= err_d;
      ss_addr_q   <= ss_addr_d;
      ss_wdat_q   <= ss_wdat_d;
      ss_we_q     <= ss_we_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdat_q  <= mem_wdat_d;
      stb_start_q <= stb_start_d;
`ifdef SS_SEQ_CHECKSUM_EN
      sum_q       <= sum_d;
      chk_q       <= chk_d;
      chk_ph_q    <= chk_ph_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    have_d      = have_q;
    err_d       = err_q;
    ss_addr_d   = ss_addr_q;
    ss_wdat_d   = ss_wdat_q;
    ss_we_d     = ss_we_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdat_d  = mem_wdat_q;
    stb_start_d = 1'b0;
`ifdef SS_SEQ_CHECKSUM_EN
    sum_d       = sum_q;
    chk_d       = chk_q;
    chk_ph_d    = chk_ph_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_save) begin
          err_d     = 1'b0;
          slot_d    = '0;
          ss_addr_d = '0;
          cnt_d     = '0;
`ifdef SS_SEQ_CHECKSUM_EN
          sum_d     = '0;
          chk_ph_d  = 1'b0;
`endif
          state_d   = SV_ADDR;
        end else if (cmd_load) begin
          err_d      = 1'b0;
          ss_addr_d  = SS_IDX_SLOT;
          cnt_d      = '0;
          have_d     = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = IDX_ADDR;
          state_d    = LD_IDX;
        end
      end
      SV_ADDR: begin
        if (cnt_q == SETTLE_LAST) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = (slot_q == SS_IDX_SLOT) ? IDX_ADDR : slot_q;
          mem_wdat_d = ss_rdat;
`ifdef SS_SEQ_CHECKSUM_EN
          sum_d      = sum_q + ss_rdat;
`endif
          state_d    = SV_MEM;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SV_MEM: begin
        if (mem_req_q && mem_ack) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          if (slot_q == LAST_SLOT) begin
            slot_d    = SS_IDX_SLOT;
            ss_addr_d = SS_IDX_SLOT;
            state_d   = SV_ADDR;
          end else if (slot_q == SS_IDX_SLOT) begin
`ifdef SS_SEQ_CHECKSUM_EN
            // The checksum write is issued from SV_MEM on the following clock.
            if (chk_ph_q) state_d  = DONE;
            else          chk_ph_d = 1'b1;
`else
            state_d = DONE;
`endif
          end else begin
            slot_d    = slot_q + 8'd1;
            ss_addr_d = slot_q + 8'd1;
            state_d   = SV_ADDR;
          end
        end
`ifdef SS_SEQ_CHECKSUM_EN
        else if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = CHK_ADDR;
          mem_wdat_d = sum_q;
        end
`endif
      end
      LD_IDX: begin
        if (cnt_q != SETTLE_LAST) cnt_d = cnt_q + 8'd1;
        if (mem_req_q && mem_ack) begin
          mem_req_d = 1'b0;
          idx_d     = mem_rdat;
          have_d    = 1'b1;
        end
        if (have_q && cnt_q == SETTLE_LAST) begin
          if (idx_q != ss_rdat) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
`ifdef SS_SEQ_CHECKSUM_EN
            sum_d      = idx_q;
            mem_addr_d = CHK_ADDR;
            state_d    = LD_CHK;
`else
            mem_addr_d = '0;
            state_d    = LD_MEM;
`endif
            slot_d    = '0;
            mem_req_d = 1'b1;
            mem_we_d  = 1'b0;
          end
        end
      end
      LD_CHK: begin
`ifdef SS_SEQ_CHECKSUM_EN
        if (mem_req_q && mem_ack) begin
          mem_req_d = 1'b0;
          chk_d     = mem_rdat;
          state_d   = LD_MEM;
        end
`else
        state_d = IDLE;
`endif
      end
      LD_MEM: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = slot_q;
        end else if (mem_ack) begin
          mem_req_d   = 1'b0;
          ss_addr_d   = slot_q;
          ss_wdat_d   = mem_rdat;
          ss_we_d     = 1'b1;
          stb_start_d = 1'b1;
`ifdef SS_SEQ_CHECKSUM_EN
          sum_d       = sum_q + mem_rdat;
`endif
          state_d     = LD_STB;
        end
      end
      LD_STB: begin
        if (stb_done) begin
          ss_we_d = 1'b0;
          if (slot_q == LAST_SLOT) begin
`ifdef SS_SEQ_CHECKSUM_EN
            if (sum_q == chk_q) begin
              state_d = DONE;
            end else begin
              err_d   = 1'b1;
              state_d = ERR;
            end
`else
            state_d = DONE;
`endif
          end else begin
            slot_d     = slot_q + 8'd1;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = slot_q + 8'd1;
            state_d    = LD_MEM;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign ss_act   = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign ss_we    = ss_we_q;
  assign ss_addr  = ss_addr_q;
  assign ss_wdat  = ss_wdat_q;
  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdat = mem_wdat_q;

endmodule
